// File: rtl/mandel_pixel_engine_pkg.sv
// Shared types and helpers for the Mandelbrot pixel engine.
package mandel_pixel_engine_pkg;

  // Colour mapping selected per pixel at accept time
  typedef enum logic [1:0] {
    CM_PALETTE     = 2'd0,
    CM_GREY        = 2'd1,
    CM_BINARY      = 2'd2,
    CM_PALETTE_ALT = 2'd3
  } color_mode_e;

  // 24-bit colour, packed as {R,G,B}
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Engine sequencing
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_COLOR = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Widest |z|^2 the escape threshold helper supports (2*64+1 bits)
  localparam int MAG_MAX_W = 129;

  // Escape threshold 4.0 expressed at the unshifted square scale (2*frac fractional bits);
  // saturates to all-ones if the threshold cannot be represented in 2*width+1 bits.
  function automatic logic [MAG_MAX_W-1:0] escape_mag(input int width, input int frac);
    logic [MAG_MAX_W-1:0] mag;
    if ((2 * frac + 3) <= (2 * width + 1)) begin
      mag = MAG_MAX_W'(32'd4) << (2 * frac);
    end else begin
      mag = '1;
    end
    return mag;
  endfunction

endpackage

// File: rtl/mandel_pixel_engine_if.sv
// Request/result handshake bundle between pixel scan, engine and frame writer.
interface mandel_pixel_engine_if #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 10,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) ();
  import mandel_pixel_engine_pkg::*;

  // request side
  logic                     in_valid;
  logic                     in_ready;
  logic [X_W-1:0]           x;
  logic [Y_W-1:0]           y;
  logic signed [WIDTH-1:0]  re_c;
  logic signed [WIDTH-1:0]  im_c;
  logic [ITER_W-1:0]        max_iter;
  logic [1:0]               color_mode;

  // result side
  logic                     out_valid;
  logic                     out_ready;
  logic [X_W-1:0]           out_x;
  logic [Y_W-1:0]           out_y;
  logic [ITER_W-1:0]        out_depth;
  logic                     out_in_set;
  rgb_t                     color;
  logic                     busy;

  modport master (
    output in_valid, x, y, re_c, im_c, max_iter, color_mode, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_depth, out_in_set, color, busy
  );

  modport slave (
    input  in_valid, x, y, re_c, im_c, max_iter, color_mode, out_ready,
    output in_ready, out_valid, out_x, out_y, out_depth, out_in_set, color, busy
  );

endinterface

// File: rtl/mandel_pixel_engine_palette.sv
// 16-entry colour ROM with a registered read port; updates only while en is high.
module mandel_pixel_engine_palette
  import mandel_pixel_engine_pkg::*;
(
  input  logic       sysclk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] addr,
  output rgb_t       rgb
);

  rgb_t rom_s;
  rgb_t rgb_d;
  rgb_t rgb_q;

  // ROM contents: dark blue through white to orange and brown
  always_comb begin
    case (addr)
      4'd0:    rom_s = 24'h421E0F;
      4'd1:    rom_s = 24'h19071A;
      4'd2:    rom_s = 24'h09012F;
      4'd3:    rom_s = 24'h040449;
      4'd4:    rom_s = 24'h000764;
      4'd5:    rom_s = 24'h0C2C8A;
      4'd6:    rom_s = 24'h1852B1;
      4'd7:    rom_s = 24'h397DD1;
      4'd8:    rom_s = 24'h86B5E5;
      4'd9:    rom_s = 24'hD3ECF8;
      4'd10:   rom_s = 24'hF1E9BF;
      4'd11:   rom_s = 24'hF8C95F;
      4'd12:   rom_s = 24'hFFAA00;
      4'd13:   rom_s = 24'hCC8000;
      4'd14:   rom_s = 24'h995700;
      4'd15:   rom_s = 24'h6A3403;
      default: rom_s = 24'h000000;
    endcase
  end

  // Capture a new entry only when enabled, otherwise hold the last read
  always_comb begin
    if (en) begin
      rgb_d = rom_s;
    end else begin
      rgb_d = rgb_q;
    end
  end

  // Read-data register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: rtl/mandel_pixel_engine.sv
// Mandelbrot pixel engine: iterates z <- z^2 + c for one pixel, then maps the
// escape depth to RGB. One pixel in flight; IDLE -> ITER -> COLOR -> OUT.
module mandel_pixel_engine
  import mandel_pixel_engine_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 10,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic                  sysclk,
  input  logic                  reset,
  mandel_pixel_engine_if.slave  bus
);

  // The escape radius 2.0 needs at least 3 integer bits plus sign
  if ((WIDTH - FRAC) < 4) begin : g_bad_frac
    $error("mandel_pixel_engine: WIDTH-FRAC must be at least 4");
  end

  localparam logic [MAG_MAX_W-1:0] ESC_MAG = escape_mag(WIDTH, FRAC);

  // state and latched request
  state_e                  state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic signed [WIDTH-1:0] re_c_q, re_c_d;
  logic signed [WIDTH-1:0] im_c_q, im_c_d;
  logic [ITER_W-1:0]       max_iter_q, max_iter_d;
  color_mode_e             mode_q, mode_d;

  // iteration state and result
  logic signed [WIDTH-1:0] zr_q, zr_d;
  logic signed [WIDTH-1:0] zi_q, zi_d;
  logic [ITER_W-1:0]       n_q, n_d;
  logic [ITER_W-1:0]       depth_q, depth_d;
  logic                    in_set_q, in_set_d;

  // registered outputs
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic [X_W-1:0]          out_x_q, out_x_d;
  logic [Y_W-1:0]          out_y_q, out_y_d;
  logic [ITER_W-1:0]       out_depth_q, out_depth_d;
  logic                    out_in_set_q, out_in_set_d;
  rgb_t                    color_q, color_d;

  // datapath
  logic signed [2*WIDTH-1:0] zr2_s;
  logic signed [2*WIDTH-1:0] zi2_s;
  logic signed [2*WIDTH-1:0] zrzi_s;
  logic [2*WIDTH:0]          mag_s;
  logic signed [2*WIDTH:0]   diff_s;
  logic signed [2*WIDTH:0]   cross_s;
  logic                      escape_s;
  logic signed [WIDTH-1:0]   zr_next_s;
  logic signed [WIDTH-1:0]   zi_next_s;
  logic                      pal_en_s;
  rgb_t                      pal_rgb_s;
  logic [7:0]                grey_s;
  rgb_t                      color_sel_s;

  // One complex squaring step: three products, full-width magnitude, scaled update
  always_comb begin
    zr2_s     = zr_q * zr_q;
    zi2_s     = zi_q * zi_q;
    zrzi_s    = zr_q * zi_q;
    mag_s     = {1'b0, zr2_s} + {1'b0, zi2_s};
    diff_s    = {zr2_s[2*WIDTH-1], zr2_s} - {zi2_s[2*WIDTH-1], zi2_s};
    cross_s   = {zrzi_s, 1'b0};
    escape_s  = (MAG_MAX_W'(mag_s) > ESC_MAG);
    zr_next_s = WIDTH'(diff_s >>> FRAC) + re_c_q;
    zi_next_s = WIDTH'(cross_s >>> FRAC) + im_c_q;
  end

  assign pal_en_s = (state_q == ST_COLOR);

  mandel_pixel_engine_palette u_palette (
    .sysclk (sysclk),
    .reset  (reset),
    .en     (pal_en_s),
    .addr   (depth_q[3:0]),
    .rgb    (pal_rgb_s)
  );

  // Final colour: points inside the set are always black
  always_comb begin
    if (32'(depth_q) > 32'd255) begin
      grey_s = 8'hFF;
    end else begin
      grey_s = 8'(depth_q);
    end
    if (in_set_q) begin
      color_sel_s = 24'h000000;
    end else begin
      case (mode_q)
        CM_GREY:   color_sel_s = {grey_s, grey_s, grey_s};
        CM_BINARY: color_sel_s = 24'hFFFFFF;
        default:   color_sel_s = pal_rgb_s;
      endcase
    end
  end

  // Next-state and next-output logic for the pixel sequence
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    re_c_d       = re_c_q;
    im_c_d       = im_c_q;
    max_iter_d   = max_iter_q;
    mode_d       = mode_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    n_d          = n_q;
    depth_d      = depth_q;
    in_set_d     = in_set_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_depth_d  = out_depth_q;
    out_in_set_d = out_in_set_q;
    color_d      = color_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.x;
          y_d        = bus.y;
          re_c_d     = bus.re_c;
          im_c_d     = bus.im_c;
          max_iter_d = bus.max_iter;
          mode_d     = color_mode_e'(bus.color_mode);
          zr_d       = '0;
          zi_d       = '0;
          n_d        = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_ITER;
        end else begin
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_ITER: begin
        if (escape_s) begin
          depth_d  = n_q;
          in_set_d = 1'b0;
          state_d  = ST_COLOR;
        end else if (n_q == max_iter_q) begin
          depth_d  = max_iter_q;
          in_set_d = 1'b1;
          state_d  = ST_COLOR;
        end else begin
          zr_d = zr_next_s;
          zi_d = zi_next_s;
          n_d  = n_q + ITER_W'(1);
        end
      end
      ST_COLOR: begin
        // palette read is in flight this cycle
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (!out_valid_q) begin
          out_x_d      = x_q;
          out_y_d      = y_q;
          out_depth_d  = depth_q;
          out_in_set_d = in_set_q;
          color_d      = color_sel_s;
          out_valid_d  = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      re_c_q       <= '0;
      im_c_q       <= '0;
      max_iter_q   <= '0;
      mode_q       <= CM_PALETTE;
      zr_q         <= '0;
      zi_q         <= '0;
      n_q          <= '0;
      depth_q      <= '0;
      in_set_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_depth_q  <= '0;
      out_in_set_q <= 1'b0;
      color_q      <= 24'h000000;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      re_c_q       <= re_c_d;
      im_c_q       <= im_c_d;
      max_iter_q   <= max_iter_d;
      mode_q       <= mode_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      n_q          <= n_d;
      depth_q      <= depth_d;
      in_set_q     <= in_set_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_depth_q  <= out_depth_d;
      out_in_set_q <= out_in_set_d;
      color_q      <= color_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_depth  = out_depth_q;
  assign bus.out_in_set = out_in_set_q;
  assign bus.color      = color_q;

endmodule

// File: tb/tb_mandel_pixel_engine.sv
// Scoreboard bench for mandel_pixel_engine: a bench-side fixed-point model
// predicts depth/colour per pixel; results are popped and compared on out_valid.
module tb_mandel_pixel_engine;

  localparam int WIDTH  = 32;
  localparam int FRAC   = 16;
  localparam int ITER_W = 10;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  localparam logic [23:0] PAL [16] = '{
    24'h421E0F, 24'h19071A, 24'h09012F, 24'h040449,
    24'h000764, 24'h0C2C8A, 24'h1852B1, 24'h397DD1,
    24'h86B5E5, 24'hD3ECF8, 24'hF1E9BF, 24'hF8C95F,
    24'hFFAA00, 24'hCC8000, 24'h995700, 24'h6A3403
  };

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ITER_W-1:0] depth;
    logic              in_set;
    logic [23:0]       color;
  } exp_t;

  logic sysclk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 sysclk = ~sysclk;

  mandel_pixel_engine_if #(.WIDTH(WIDTH), .ITER_W(ITER_W), .X_W(X_W), .Y_W(Y_W)) bus ();

  mandel_pixel_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference iteration with wide integers
  function automatic void model(input logic signed [31:0] re, input logic signed [31:0] im,
                                input logic [9:0] mit, output int depth, output bit in_set);
    logic signed [31:0]  zr, zi;
    logic signed [127:0] zr2, zi2, zrzi, mag, t, lim;
    zr = 32'sd0;
    zi = 32'sd0;
    depth = 0;
    in_set = 1'b0;
    lim = 128'sd4 <<< (2 * FRAC);
    for (int n = 0; n <= 1023; n++) begin
      zr2  = zr * zr;
      zi2  = zi * zi;
      zrzi = zr * zi;
      mag  = zr2 + zi2;
      if (mag > lim) begin
        depth = n;
        in_set = 1'b0;
        return;
      end else if (n == int'(mit)) begin
        depth = n;
        in_set = 1'b1;
        return;
      end
      t  = (zr2 - zi2) >>> FRAC;
      zr = t[31:0] + re;
      t  = (zrzi <<< 1) >>> FRAC;
      zi = t[31:0] + im;
    end
  endfunction

  function automatic logic [23:0] exp_color(input int depth, input bit in_set, input logic [1:0] mode);
    logic [7:0] g;
    logic [3:0] a;
    if (in_set) return 24'h000000;
    g = (depth > 255) ? 8'hFF : 8'(depth);
    a = 4'(depth);
    case (mode)
      2'd1:    return {g, g, g};
      2'd2:    return 24'hFFFFFF;
      default: return PAL[a];
    endcase
  endfunction

  task automatic run_pixel(input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                           input logic signed [31:0] re, input logic signed [31:0] im,
                           input logic [9:0] mit, input logic [1:0] mode,
                           input int hold, input bit noise);
    exp_t e;
    int   d;
    bit   s;
    int   w;
    int   lat;
    model(re, im, mit, d, s);
    e.x = px;
    e.y = py;
    e.depth = 10'(d);
    e.in_set = s;
    e.color = exp_color(d, s, mode);
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(posedge sysclk); #1;
      w++;
    end
    check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
    sb.push_back(e);
    bus.x = px; bus.y = py; bus.re_c = re; bus.im_c = im;
    bus.max_iter = mit; bus.color_mode = mode; bus.in_valid = 1'b1;
    @(posedge sysclk); #1;
    check_eq("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    check_eq("busy_after_accept", 64'(bus.busy), 64'd1);
    // optional stray request while busy; it must be ignored
    bus.in_valid = noise;
    if (noise) begin
      bus.x = px ^ 10'd1; bus.re_c = 32'sd0; bus.im_c = 32'sd0; bus.max_iter = 10'd5;
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 1100) begin
      @(posedge sysclk); #1;
      lat++;
      if (lat >= 3) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check_eq("out_valid_seen", 64'(bus.out_valid), 64'd1);
    check_eq("latency", 64'(lat), 64'(d + 3));
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_depth", 64'(bus.out_depth), 64'(e.depth));
      check_eq("hold_color", 64'(bus.color), 64'(e.color));
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge sysclk); #1;
    end
    e = sb.pop_front();
    check_eq("out_x", 64'(bus.out_x), 64'(e.x));
    check_eq("out_y", 64'(bus.out_y), 64'(e.y));
    check_eq("out_depth", 64'(bus.out_depth), 64'(e.depth));
    check_eq("out_in_set", 64'(bus.out_in_set), 64'(e.in_set));
    check_eq("color", 64'(bus.color), 64'(e.color));
    bus.out_ready = 1'b1;
    @(posedge sysclk); #1;
    bus.out_ready = 1'b0;
    check_eq("out_valid_cleared", 64'(bus.out_valid), 64'd0);
    check_eq("in_ready_after_out", 64'(bus.in_ready), 64'd1);
    check_eq("busy_after_out", 64'(bus.busy), 64'd0);
  endtask

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic signed [31:0] rr, ri;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.y = '0; bus.re_c = '0; bus.im_c = '0;
    bus.max_iter = '0; bus.color_mode = 2'd0;
    #1;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_color", 64'(bus.color), 64'd0);
    check_eq("rst_depth", 64'(bus.out_depth), 64'd0);
    @(posedge sysclk); @(posedge sysclk); #1;
    reset = 1'b0;

    run_pixel(10'd1,   9'd2,  32'sh00000000, 32'sh00000000, 10'd200, 2'd0, 0, 1'b1);
    run_pixel(10'd3,   9'd4,  32'sh00020000, 32'sh00000000, 10'd200, 2'd1, 0, 1'b0);
    run_pixel(10'd5,   9'd6,  32'sh00020000, 32'sh00000000, 10'd200, 2'd2, 0, 1'b0);
    run_pixel(10'd7,   9'd8,  32'shFFFE0000, 32'sh00000000, 10'd200, 2'd0, 0, 1'b0);
    run_pixel(10'd9,   9'd10, 32'sh00010000, 32'sh00000000, 10'd200, 2'd0, 10, 1'b0);
    run_pixel(10'd11,  9'd12, 32'sh00020000, 32'sh00000000, 10'd0,   2'd2, 0, 1'b0);
    run_pixel(10'd13,  9'd14, 32'sh00008000, 32'sh00010000, 10'd50,  2'd3, 0, 1'b0);
    run_pixel(10'd1023, 9'd511, 32'sh00004007, 32'sh00000000, 10'd1023, 2'd1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      r  = int'($urandom_range(0, 327680)) - 163840;
      rr = 32'(r);
      r  = int'($urandom_range(0, 262144)) - 131072;
      ri = 32'(r);
      run_pixel(10'(k + 100), 9'(k + 200), rr, ri, 10'd30, 2'($urandom_range(0, 3)), 0, 1'b0);
    end

    // reset in the middle of an iteration drops the pixel
    bus.x = 10'd77; bus.y = 9'd77; bus.re_c = 32'sh0; bus.im_c = 32'sh0;
    bus.max_iter = 10'd200; bus.color_mode = 2'd0; bus.in_valid = 1'b1;
    @(posedge sysclk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge sysclk);
    #3;
    check_eq("busy_mid_iter", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    @(posedge sysclk); #1;
    reset = 1'b0;
    run_pixel(10'd21, 9'd22, 32'sh00020000, 32'sh00000000, 10'd200, 2'd1, 0, 1'b0);

    check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
